// File: rtl/multi_receiver_arbiter.sv
// Round-robin collector of per-channel decoder words into a first-word-fall-through FIFO
// with registered head outputs and a one-cycle decoder clear pulse per capture.
module multi_receiver_arbiter #(
  parameter int NB_CHANNELS = 4,
  parameter int DATA_WIDTH  = 17,
  parameter int TS_WIDTH    = 24,
  parameter int FIFO_DEPTH  = 8,
  localparam int CH_W       = $clog2(NB_CHANNELS),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clk_96MHz,
  input  logic                              reset_n,
  input  logic [NB_CHANNELS-1:0]            data_availible,
  input  logic [NB_CHANNELS*DATA_WIDTH-1:0] decoded_data,
  input  logic [NB_CHANNELS*TS_WIDTH-1:0]   timestamp_last_data,
  output logic [NB_CHANNELS-1:0]            reset_decoder,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [TS_WIDTH-1:0]               out_timestamp,
  output logic [CH_W-1:0]                   out_channel,
  output logic [CNT_W-1:0]                  fifo_count,
  output logic [NB_CHANNELS-1:0]            stall_seen
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + TS_WIDTH + CH_W;

  logic [NB_CHANNELS-1:0] mask_q, mask_d;
  logic [NB_CHANNELS-1:0] stall_q, stall_d;
  logic [NB_CHANNELS-1:0] reset_decoder_q, reset_decoder_d;
  logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [TS_WIDTH-1:0]    out_ts_q, out_ts_d;
  logic [CH_W-1:0]        out_ch_q, out_ch_d;

  logic [NB_CHANNELS-1:0] eligible_s;
  logic                   found_s;
  logic [CH_W-1:0]        grant_idx_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   grant_s;
  logic [ENTRY_W-1:0]     push_word_s;
  logic [PTR_W-1:0]       head_idx_s;
  logic [ENTRY_W-1:0]     head_s;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    eligible_s  = data_availible & ~mask_q;
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int i = 1; i <= NB_CHANNELS; i++) begin
      int  idx;
      logic hit;
      idx         = (int'(rr_ptr_q) + i) % NB_CHANNELS;
      hit         = !found_s && eligible_s[idx];
      grant_idx_s = hit ? CH_W'(idx) : grant_idx_s;
      found_s     = found_s | hit;
    end
  end

  // Grant qualification, FIFO bookkeeping and next head selection
  always_comb begin
    pop_s   = out_valid_q & out_ready;
    full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    grant_s = found_s && (!full_s || pop_s);

    push_word_s = {decoded_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH],
                   timestamp_last_data[grant_idx_s*TS_WIDTH +: TS_WIDTH],
                   grant_idx_s};

    rr_ptr_d        = grant_s ? grant_idx_s : rr_ptr_q;
    reset_decoder_d = grant_s ? ({{(NB_CHANNELS-1){1'b0}}, 1'b1} << grant_idx_s)
                              : {NB_CHANNELS{1'b0}};
    // A mask lives until the decoder's flag is seen low, blocking a recapture of the same word
    mask_d  = (mask_q & data_availible) | reset_decoder_d;
    stall_d = stall_q | ((full_s && !pop_s) ? eligible_s : {NB_CHANNELS{1'b0}});

    wr_ptr_d = wr_ptr_q + PTR_W'(grant_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    count_d  = count_q + CNT_W'(grant_s) - CNT_W'(pop_s);

    // Head register reflects stored words only, so a fresh push appears one edge later
    head_idx_s  = rd_ptr_q + PTR_W'(pop_s);
    head_s      = mem_q[head_idx_s];
    out_valid_d = ((count_q - CNT_W'(pop_s)) != {CNT_W{1'b0}});
    if (out_valid_d) begin
      out_data_d = head_s[ENTRY_W-1 -: DATA_WIDTH];
      out_ts_d   = head_s[CH_W+TS_WIDTH-1 -: TS_WIDTH];
      out_ch_d   = head_s[CH_W-1:0];
    end else begin
      out_data_d = out_data_q;
      out_ts_d   = out_ts_q;
      out_ch_d   = out_ch_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      mask_q          <= {NB_CHANNELS{1'b0}};
      stall_q         <= {NB_CHANNELS{1'b0}};
      reset_decoder_q <= {NB_CHANNELS{1'b0}};
      rr_ptr_q        <= CH_W'(NB_CHANNELS - 1);
      wr_ptr_q        <= {PTR_W{1'b0}};
      rd_ptr_q        <= {PTR_W{1'b0}};
      count_q         <= {CNT_W{1'b0}};
      out_valid_q     <= 1'b0;
      out_data_q      <= {DATA_WIDTH{1'b0}};
      out_ts_q        <= {TS_WIDTH{1'b0}};
      out_ch_q        <= {CH_W{1'b0}};
    end else begin
      mask_q          <= mask_d;
      stall_q         <= stall_d;
      reset_decoder_q <= reset_decoder_d;
      rr_ptr_q        <= rr_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_ts_q        <= out_ts_d;
      out_ch_q        <= out_ch_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else if (grant_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign reset_decoder = reset_decoder_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_timestamp = out_ts_q;
  assign out_channel   = out_ch_q;
  assign fifo_count    = count_q;
  assign stall_seen    = stall_q;

endmodule

// File: tb/tb_multi_receiver_arbiter.sv
// Directed bench for multi_receiver_arbiter: single capture, fairness, full FIFO,
// simultaneous push/pop at full, slow flag drop and reset mid-run.
module tb_multi_receiver_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  da;
  logic [67:0] decoded_data;
  logic [95:0] timestamp_last_data;
  logic [3:0]  reset_decoder;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [23:0] out_timestamp;
  logic [1:0]  out_channel;
  logic [3:0]  fifo_count;
  logic [3:0]  stall_seen;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_data [4];
  logic [23:0] exp_ts [4];

  multi_receiver_arbiter dut (
    .clk_96MHz           (clk),
    .reset_n             (reset_n),
    .data_availible      (da),
    .decoded_data        (decoded_data),
    .timestamp_last_data (timestamp_last_data),
    .reset_decoder       (reset_decoder),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_timestamp       (out_timestamp),
    .out_channel         (out_channel),
    .fifo_count          (fifo_count),
    .stall_seen          (stall_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int ch);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_chan"}, 32'(out_channel), 32'(ch));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data[ch]));
    check({tag, "_ts"}, 32'(out_timestamp), 32'(exp_ts[ch]));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    exp_data[0] = 17'h00A01; exp_ts[0] = 24'h100000;
    exp_data[1] = 17'h0B012; exp_ts[1] = 24'h200011;
    exp_data[2] = 17'h1ABCD; exp_ts[2] = 24'h00F00D;
    exp_data[3] = 17'h1F00F; exp_ts[3] = 24'hFFFFFF;
    decoded_data        = {17'h1F00F, 17'h1ABCD, 17'h0B012, 17'h00A01};
    timestamp_last_data = {24'hFFFFFF, 24'h00F00D, 24'h200011, 24'h100000};
    reset_n   = 1'b0;
    da        = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_rd", 32'(reset_decoder), 32'd0);
    check("rst_stall", 32'(stall_seen), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single capture on channel 2
    da = 4'b0100;
    tick();
    check("t1_rd", 32'(reset_decoder), 32'h4);
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    check("t1_count", 32'(fifo_count), 32'd1);
    da = 4'b0000;
    tick();
    check("t1_rd_off", 32'(reset_decoder), 32'd0);
    check_word("t1_word", 2);
    tick();
    check_word("t1_hold", 2);
    out_ready = 1'b1;
    tick();
    check("t1_pop_valid", 32'(out_valid), 32'd0);
    check("t1_pop_count", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;

    // Fairness: decoders drop their flag on clear and re-raise one cycle later
    do_reset();
    da = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_rd", 32'(reset_decoder), 32'(4'b0001 << (i % 4)));
      if (i >= 1) begin
        check_word("t2_out", (i - 1) % 4);
        da[(i - 1) % 4] = 1'b1;
      end
      da[i % 4] = 1'b0;
    end
    da = 4'b0000;
    out_ready = 1'b0;

    // Full FIFO, stall, then grant together with a pop at full occupancy
    do_reset();
    da = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_rd", 32'(reset_decoder), 32'(4'b0001 << (i % 4)));
      check("t3_count", 32'(fifo_count), 32'(i + 1));
      if (i >= 1) begin
        da[(i - 1) % 4] = 1'b1;
      end
      da[i % 4] = 1'b0;
    end
    tick();
    check("t3_stall_rd", 32'(reset_decoder), 32'd0);
    check("t3_stall_count", 32'(fifo_count), 32'd8);
    check("t3_stall_seen", 32'(stall_seen), 32'h7);
    tick();
    check("t3_stall_rd2", 32'(reset_decoder), 32'd0);
    out_ready = 1'b1;
    tick();
    check("t4_rd", 32'(reset_decoder), 32'h1);
    check("t4_count", 32'(fifo_count), 32'd8);
    check("t4_stall_sticky", 32'(stall_seen), 32'h7);
    out_ready = 1'b0;
    da = 4'b0000;
    for (int j = 0; j < 8; j++) begin
      check_word("t3_drain", (j + 1) % 4);
      out_ready = 1'b1;
      tick();
    end
    check("t3_empty_valid", 32'(out_valid), 32'd0);
    check("t3_empty_count", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;

    // Slow flag drop on channel 1
    do_reset();
    da = 4'b0010;
    tick();
    check("t5_rd", 32'(reset_decoder), 32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_rd_quiet", 32'(reset_decoder), 32'd0);
      check("t5_count", 32'(fifo_count), 32'd1);
    end
    da = 4'b0000;
    repeat (2) tick();
    check("t5_count_end", 32'(fifo_count), 32'd1);
    check_word("t5_word", 1);

    // Reset mid-run with five buffered words
    do_reset();
    da = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_rd", 32'(reset_decoder), 32'(4'b0001 << (i % 4)));
      if (i >= 1) begin
        da[(i - 1) % 4] = 1'b1;
      end
      da[i % 4] = 1'b0;
    end
    check("t6_count5", 32'(fifo_count), 32'd5);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_rd", 32'(reset_decoder), 32'd0);
    da = 4'b1111;
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_regrant0", 32'(reset_decoder), 32'h1);
    check("t6_count1", 32'(fifo_count), 32'd1);
    da[0] = 1'b0;
    tick();
    check("t6_regrant1", 32'(reset_decoder), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
